// File: rtl/vend_pkg.sv
// Shared vending constants: coin one-hot encodings, cent values and dispenser states.
// The coin encodings are also used by the coin-acceptor path.
package vend_pkg;

    localparam logic [2:0] COIN_5  = 3'b001;
    localparam logic [2:0] COIN_10 = 3'b010;
    localparam logic [2:0] COIN_25 = 3'b100;

    localparam int CENTS_5  = 5;
    localparam int CENTS_10 = 10;
    localparam int CENTS_25 = 25;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_PULSE,
        ST_GAP,
        ST_DONE
    } state_t;

endpackage

// File: rtl/tick_counter.sv
// Counts enabled ticks up to a load value; term pulses on the tick that reaches it.
module tick_counter #(
    parameter int TICK_W = 4
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              restart,
    input  logic              enable,
    input  logic [TICK_W-1:0] load,
    output logic              term
);

    logic [TICK_W-1:0] count;

    assign term = enable && (count + 1'b1 == load);

    // Self-clears on term so back-to-back intervals need no explicit restart.
    always_ff @(posedge clk) begin
        if (clr || restart) begin
            count <= '0;
        end else if (enable) begin
            count <= term ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/change_dispenser.sv
// Greedy change dispenser: emits timed one-hot coin pulses, largest coin first.
// Optional per-denomination coin stock with refill/short ports under COIN_STOCK_EN.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int AMT_W       = 8,
    parameter int PULSE_TICKS = 2,
    parameter int GAP_TICKS   = 2,
    parameter int TICK_W      = 4
`ifdef COIN_STOCK_EN
    ,
    parameter int INIT_STOCK  = 8
`endif
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             clk_en,
    input  logic             start,
    input  logic [AMT_W-1:0] amount,
    output logic [2:0]       coin_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AMT_W-1:0] remaining
`ifdef COIN_STOCK_EN
    ,
    input  logic             refill,
    output logic             short
`endif
);

    state_t           state;
    logic [2:0]       avail;
    logic [2:0]       pick;
    logic [AMT_W-1:0] coin_val;
    logic             term;

`ifdef COIN_STOCK_EN
    logic [2:0][3:0] stock;

    always_comb begin
        avail = 3'b000;
        for (int i = 0; i < 3; i++) avail[i] = (stock[i] != 4'd0);
    end
`else
    assign avail = 3'b111;
`endif

    always_comb begin
        pick = 3'b000;
        if (avail[2] && remaining >= AMT_W'(CENTS_25))      pick = COIN_25;
        else if (avail[1] && remaining >= AMT_W'(CENTS_10)) pick = COIN_10;
        else if (avail[0] && remaining >= AMT_W'(CENTS_5))  pick = COIN_5;
    end

    always_comb begin
        case (coin_out)
            COIN_25: coin_val = AMT_W'(CENTS_25);
            COIN_10: coin_val = AMT_W'(CENTS_10);
            COIN_5:  coin_val = AMT_W'(CENTS_5);
            default: coin_val = '0;
        endcase
    end

    tick_counter #(.TICK_W(TICK_W)) u_tick (
        .clk     (clk),
        .clr     (clr),
        .restart (state == ST_SELECT),
        .enable  (clk_en && (state == ST_PULSE || state == ST_GAP)),
        .load    (state == ST_PULSE ? TICK_W'(PULSE_TICKS) : TICK_W'(GAP_TICKS)),
        .term    (term)
    );

    assign busy = (state == ST_SELECT) || (state == ST_PULSE) || (state == ST_GAP);
    assign done = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (clr) begin
            state     <= ST_IDLE;
            coin_out  <= 3'b000;
            err       <= 1'b0;
            remaining <= '0;
`ifdef COIN_STOCK_EN
            short     <= 1'b0;
            stock     <= {3{4'(INIT_STOCK)}};
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        remaining <= amount;
                        err       <= 1'b0;
`ifdef COIN_STOCK_EN
                        short     <= 1'b0;
`endif
                        state     <= ST_SELECT;
                    end
`ifdef COIN_STOCK_EN
                    else if (refill) begin
                        stock <= {3{4'(INIT_STOCK)}};
                    end
`endif
                end
                ST_SELECT: begin
                    if (pick != 3'b000) begin
                        coin_out <= pick;
                        state    <= ST_PULSE;
                    end else begin
                        // Nothing dispensable left: either a sub-nickel residue or no stock.
                        if (remaining != '0) begin
`ifdef COIN_STOCK_EN
                            if (remaining < AMT_W'(CENTS_5)) err <= 1'b1;
                            else                             short <= 1'b1;
`else
                            err <= 1'b1;
`endif
                        end
                        state <= ST_DONE;
                    end
                end
                ST_PULSE: begin
                    if (term) begin
                        remaining <= remaining - coin_val;
                        coin_out  <= 3'b000;
`ifdef COIN_STOCK_EN
                        for (int i = 0; i < 3; i++)
                            if (coin_out[i]) stock[i] <= stock[i] - 4'd1;
`endif
                        state     <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (term) state <= ST_SELECT;
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
